// File: rtl/uart_8n1_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_8n1_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] SAMPLE_END = 4'(OVERSAMPLE - 1);
  localparam int         DATA_BITS  = 8;

  // Two-of-three vote; filters single-sample noise on the line
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-flop synchronizer for an asynchronous input; flops reset to 1 so an
// idle-high line does not look like a falling edge after reset.
module uart_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Shift the raw input through the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_8n1_receiver.sv
// 8N1 UART receiver clocked at 16x the baud rate. The start bit is validated
// at mid-bit, data and stop bits are sampled one bit-time apart using a
// majority-voted copy of the synchronized line.
module uart_8n1_receiver
  import uart_8n1_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic       clk_baud_16x,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_avail,
  input  logic       recv_read,
  output logic       recv_overrun,
  output logic       recv_frame_error,
  output logic       recv_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_sync;
  logic [2:0]           hist_reg;
  logic                 rx_vote;

  rx_state_e            state_reg, state_next;
  logic [3:0]           tick_reg, tick_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] data_sr_reg, data_sr_next;
  logic                 byte_done;
  logic                 frame_err;

  uart_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk_baud_16x),
    .reset(reset),
    .d    (rx),
    .q    (rx_sync)
  );

  // Keep the last three synchronized samples for the majority vote
  always_ff @(posedge clk_baud_16x or posedge reset) begin
    if (reset) begin
      hist_reg <= 3'b111;
    end else begin
      hist_reg <= {hist_reg[1:0], rx_sync};
    end
  end

  assign rx_vote = majority3(hist_reg);

  // FSM state, bit-time counter, bit index and shift register
  always_ff @(posedge clk_baud_16x or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      tick_reg    <= 4'd0;
      bit_idx_reg <= 3'd0;
      data_sr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_idx_reg <= bit_idx_next;
      data_sr_reg <= data_sr_next;
    end
  end

  // Next-state logic; the counter free-runs (and wraps) outside IDLE
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg + 4'd1;
    bit_idx_next = bit_idx_reg;
    data_sr_next = data_sr_reg;
    byte_done    = 1'b0;
    frame_err    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        tick_next = 4'd0;
        if (!rx_sync) begin
          state_next = START;
        end
      end

      START: begin
        if (tick_reg == SAMPLE_MID) begin
          if (!rx_vote) begin
            state_next   = DATA;
            tick_next    = 4'd0;
            bit_idx_next = 3'd0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (tick_reg == SAMPLE_END) begin
          data_sr_next = {rx_vote, data_sr_reg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (tick_reg == SAMPLE_END) begin
          if (rx_vote) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end
      end

      BREAK: begin
        // Wait for the line to recover so a held-low line is not a start bit
        if (rx_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Consumer-facing holding register, availability and overrun tracking
  always_ff @(posedge clk_baud_16x or posedge reset) begin
    if (reset) begin
      recv_data        <= 8'h00;
      recv_avail       <= 1'b0;
      recv_overrun     <= 1'b0;
      recv_frame_error <= 1'b0;
    end else begin
      recv_frame_error <= frame_err;
      if (byte_done) begin
        recv_data  <= data_sr_reg;
        recv_avail <= 1'b1;
        // A read in the same cycle consumes the old byte, so no overrun
        if (recv_avail) begin
          recv_overrun <= ~recv_read;
        end
      end else if (recv_read && recv_avail) begin
        recv_avail   <= 1'b0;
        recv_overrun <= 1'b0;
      end
    end
  end

  assign recv_busy = (state_reg != IDLE);

endmodule
